// File: rtl/output_port_pkg.sv
// output_port_pkg: NIC-wide flit geometry, VC/credit sizing and FSM encodings shared by output_port and vc_allocator.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 16
`endif
package output_port_pkg;
    localparam int FLIT_WIDTH          = `FLIT_WIDTH;
    localparam int MAX_PACKET_LENGHT   = `MAX_PACKET_LENGHT;
    localparam int N_TOT_OF_VC         = 4;
    localparam int N_BITS_POINTER      = 2;
    localparam int N_BITS_FLIT_COUNTER = 5;
    localparam int N_CREDITS           = 4;
    localparam int N_BITS_CREDIT       = 3;
    localparam int N_BITS_FLIT_INDEX   = $clog2(MAX_PACKET_LENGHT);

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ALLOC = 2'd1;
    localparam state_t SEND  = 2'd2;

    // A zero length still carries a head flit; oversize lengths cannot exceed the packet buffer.
    function automatic logic [N_BITS_FLIT_COUNTER-1:0] clamp_len(input logic [N_BITS_FLIT_COUNTER-1:0] len);
        return (len == '0) ? N_BITS_FLIT_COUNTER'(1) :
               (len > N_BITS_FLIT_COUNTER'(MAX_PACKET_LENGHT)) ? N_BITS_FLIT_COUNTER'(MAX_PACKET_LENGHT) : len;
    endfunction
endpackage

// File: rtl/output_port_vc_allocator.sv
// vc_allocator: picks one eligible downstream VC; round-robin when OUTPUT_PORT_ROUND_ROBIN_EN is defined, else lowest index.
module vc_allocator
    import output_port_pkg::*;
(
`ifdef OUTPUT_PORT_ROUND_ROBIN_EN
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_grant,
`endif
    input  logic [N_TOT_OF_VC-1:0]    i_eligible,
    output logic                      o_grant_valid,
    output logic [N_BITS_POINTER-1:0] o_grant_idx
);
    assign o_grant_valid = |i_eligible;
`ifdef OUTPUT_PORT_ROUND_ROBIN_EN
    logic [N_BITS_POINTER-1:0] r_last;
    logic [N_BITS_POINTER-1:0] w_j;
    // Scan downward so the candidate nearest to r_last+1 is written last and wins.
    always_comb begin
        o_grant_idx = '0;
        w_j = '0;
        for (int k = N_TOT_OF_VC - 1; k >= 0; k--) begin
            w_j = r_last + N_BITS_POINTER'(k + 1);
            if (i_eligible[w_j]) o_grant_idx = w_j;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_last <= N_BITS_POINTER'(N_TOT_OF_VC - 1);
        else if (i_grant) r_last <= o_grant_idx;
    end
`else
    logic [N_BITS_POINTER-1:0] w_j;
    always_comb begin
        o_grant_idx = '0;
        w_j = '0;
        for (int k = N_TOT_OF_VC - 1; k >= 0; k--) begin
            w_j = N_BITS_POINTER'(k);
            if (i_eligible[w_j]) o_grant_idx = w_j;
        end
    end
`endif
endmodule

// File: rtl/output_port.sv
// output_port: serializes one latched packet into flits on a credit-controlled downstream VC.
// Build option OUTPUT_PORT_ROUND_ROBIN_EN selects round-robin VC allocation instead of fixed priority.
module output_port
    import output_port_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    r_msg_to_pkt_i,
    input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i,
    input  logic [N_BITS_FLIT_COUNTER-1:0]          packet_lenght_i,
    output logic                                    stall_msg_to_pkt_o,
    output logic [FLIT_WIDTH-1:0]                   out_link_o,
    output logic                                    is_valid_o,
    output logic [N_BITS_POINTER-1:0]               vc_o,
    input  logic [N_TOT_OF_VC-1:0]                  credit_signal_i,
    input  logic [N_TOT_OF_VC-1:0]                  free_signal_i
);
    state_t                                             r_state;
    logic [MAX_PACKET_LENGHT-1:0][FLIT_WIDTH-1:0]       r_packet;
    logic [N_BITS_FLIT_COUNTER-1:0]                     r_len;
    logic [N_BITS_FLIT_COUNTER-1:0]                     r_flit_cnt;
    logic [N_BITS_POINTER-1:0]                          r_vc;
    logic [N_TOT_OF_VC-1:0]                             r_vc_free;
    logic [N_TOT_OF_VC-1:0][N_BITS_CREDIT-1:0]          r_credit;
    logic [N_TOT_OF_VC-1:0][N_BITS_CREDIT-1:0]          w_credit_next;
    logic [N_TOT_OF_VC-1:0]                             w_vc_free_next;
    logic [N_TOT_OF_VC-1:0]                             w_eligible;
    logic [N_TOT_OF_VC-1:0]                             w_sent;
    logic                                               w_send;
    logic                                               w_last;
    logic                                               w_accept;
    logic                                               w_alloc;
    logic                                               w_grant_valid;
    logic [N_BITS_POINTER-1:0]                          w_grant_idx;

    assign w_send             = (r_state == SEND) && (r_credit[r_vc] != '0);
    assign w_last             = r_flit_cnt == r_len - N_BITS_FLIT_COUNTER'(1);
    assign w_accept           = r_msg_to_pkt_i && (r_state == IDLE);
    assign w_alloc            = (r_state == ALLOC) && w_grant_valid;
    assign stall_msg_to_pkt_o = r_state != IDLE;
    assign is_valid_o         = w_send;
    assign out_link_o         = (r_state == SEND) ? r_packet[r_flit_cnt[N_BITS_FLIT_INDEX-1:0]] : '0;
    assign vc_o               = (r_state == SEND) ? r_vc : '0;
    // A claim by ALLOC overrides a free pulse on the same VC.
    assign w_vc_free_next     = (r_vc_free | free_signal_i) & ~(w_alloc ? N_TOT_OF_VC'(1) << w_grant_idx : '0);

    // Returning a credit to a full counter is a downstream protocol error; hold at N_CREDITS.
    always_comb begin
        w_sent        = '0;
        w_eligible    = '0;
        w_credit_next = r_credit;
        for (int i = 0; i < N_TOT_OF_VC; i++) begin
            w_sent[i]        = w_send && (r_vc == N_BITS_POINTER'(i));
            w_eligible[i]    = r_vc_free[i] && (r_credit[i] != '0);
            w_credit_next[i] = (credit_signal_i[i] && !w_sent[i] && r_credit[i] == N_BITS_CREDIT'(N_CREDITS)) ? r_credit[i] :
                               r_credit[i] + N_BITS_CREDIT'(credit_signal_i[i]) - N_BITS_CREDIT'(w_sent[i]);
        end
    end

    vc_allocator u_vc_allocator (
`ifdef OUTPUT_PORT_ROUND_ROBIN_EN
        .clk           (clk),
        .rst           (rst),
        .i_grant       (w_alloc),
`endif
        .i_eligible    (w_eligible),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_packet   <= '0;
            r_len      <= '0;
            r_flit_cnt <= '0;
            r_vc       <= '0;
            r_vc_free  <= '1;
            r_credit   <= {N_TOT_OF_VC{N_BITS_CREDIT'(N_CREDITS)}};
        end else begin
            r_credit  <= w_credit_next;
            r_vc_free <= w_vc_free_next;
            if (w_accept) begin
                r_state    <= ALLOC;
                r_packet   <= in_link_i;
                r_len      <= clamp_len(packet_lenght_i);
                r_flit_cnt <= '0;
            end else if (w_alloc) begin
                r_state <= SEND;
                r_vc    <= w_grant_idx;
            end else if (w_send) begin
                r_flit_cnt <= r_flit_cnt + N_BITS_FLIT_COUNTER'(1);
                if (w_last) r_state <= IDLE;
            end else if (r_state > SEND) begin
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: doc/output_port.md
# output_port

Flit-serializing output port of the NIC injection path (WB slave side → message-to-packet stage → output_port → router). It accepts one fully assembled packet at a time and allocates a free virtual channel of the downstream router input port. It streams the packet's flits onto the router link under per-VC credit-based flow control. It is the mirror of the NIC input port and drives the link that a router input port, or another NIC input port, consumes.

## Interface
- N_TOT_OF_VC, 4: virtual channels on the link
- N_BITS_POINTER, 2: width of a VC index, clog2(N_TOT_OF_VC)
- N_BITS_FLIT_COUNTER, 5: flit counter width, clog2(`MAX_PACKET_LENGHT + 1)
- N_CREDITS, 4: flit buffer depth per downstream VC; also the credit reset value
- N_BITS_CREDIT, 3: credit counter width, clog2(N_CREDITS + 1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- r_msg_to_pkt_i  in  1  packet request (valid)
- in_link_i  in  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet; flit k = bits [(k+1)*`FLIT_WIDTH-1 : k*`FLIT_WIDTH], flit 0 = head
- packet_lenght_i  in  N_BITS_FLIT_COUNTER  flit count, legal range 1..`MAX_PACKET_LENGHT
- stall_msg_to_pkt_o  out  1  high = packet not accepted this cycle
- out_link_o  out  `FLIT_WIDTH  flit to router
- is_valid_o  out  1  out_link_o carries a valid flit
- vc_o  out  N_BITS_POINTER  VC of the current flit
- credit_signal_i  in  N_TOT_OF_VC  one-cycle pulse per VC; one flit slot freed downstream
- free_signal_i  in  N_TOT_OF_VC  one-cycle pulse per VC; downstream VC has returned to idle

## Operation
- Handshake: a packet is accepted on an edge where r_msg_to_pkt_i=1 and stall_msg_to_pkt_o=0. in_link_i and packet_lenght_i are latched into packet_r and len_r. flit_cnt is cleared.
- stall_msg_to_pkt_o = (state != IDLE).
- FSM:
  - IDLE → ALLOC on acceptance.
  - ALLOC: choose a VC i with vc_free_r[i]=1 and credit_r[i]!=0. On the edge it is chosen: vc_r<=i, vc_free_r[i]<=0, go to SEND. With no eligible VC, remain in ALLOC.
  - SEND: if credit_r[vc_r]!=0, drive flit flit_cnt and increment flit_cnt on the edge. The edge that consumes flit len_r-1 returns the FSM to IDLE. With zero credit, is_valid_o=0 and the FSM holds.
- is_valid_o = (state==SEND) && credit_r[vc_r]!=0.
  - out_link_o = slice flit_cnt of packet_r.
  - vc_o = vc_r.
  - All three are combinational from registers.
  - Outside SEND, out_link_o and vc_o are 0.
- Credits, per VC: next = credit_r + credit_signal_i[i] - (flit sent on i).
  - A simultaneous return and send leaves the count unchanged.
  - A return at N_CREDITS with no send is a protocol error: the count saturates at N_CREDITS.
- free_signal_i[i] sets vc_free_r[i]. If ALLOC claims the same VC in the same cycle, the claim wins.
- packet_lenght_i=0 is treated as 1. Values above `MAX_PACKET_LENGHT are clamped to `MAX_PACKET_LENGHT.
- Reset (rst=0, any time, including mid-packet): state=IDLE, credit_r[*]=N_CREDITS, vc_free_r[*]=1, flit_cnt=0, vc_r=0, packet_r=0. The partial packet is dropped.

## Timing
- Reset values of outputs: stall_msg_to_pkt_o=0, is_valid_o=0, out_link_o=0, vc_o=0.
- Acceptance edge t0; ALLOC edge t1; head flit valid during the cycle after t1. Latency is 2 cycles when a VC is available.
- Throughput is 1 flit/cycle while credits last.
- Minimum one IDLE cycle between packets: stall deasserts in the cycle after the last flit's edge.
- A credit returned on edge t is usable in the cycle after t.

## Configuration
- OUTPUT_PORT_ROUND_ROBIN_EN defined: VC allocation is round-robin. The search starts at (last granted VC + 1) mod N_TOT_OF_VC, and the pointer updates only on a grant.
- Not defined: fixed priority, lowest eligible index wins.

## Structure
- `FLIT_WIDTH and `MAX_PACKET_LENGHT come from NIC-defines.v, which is shared.
- FSM state encodings are localparams in NIC-defines.v, shared with input_port.
- One sub-module: vc_allocator.
  - Inputs: eligibility vector (vc_free_r & credit_r!=0) and the grant strobe.
  - Outputs: grant_valid and grant index.
  - Contains the round-robin pointer under the macro.

## Test plan
- Reset, then 3-flit packet with all VCs free → accepted t0; flits 0,1,2 on VC 0 in cycles t0+2..t0+4; stall low at t0+5; credit_r[0]=1.
- 6-flit packet, N_CREDITS=4, no returns → 4 flits sent, then is_valid_o=0 hold. Credit pulse on VC 0 → flit 4 the next cycle; a second pulse → flit 5; then IDLE.
- vc_free_r[0] cleared by a prior packet, no free pulse → second packet uses VC 1. free_signal_i[0] pulse → third packet uses VC 0 (fixed priority) or VC 2 (round-robin build).
- All VCs busy → stall stays high in ALLOC. free_signal_i[2] pulse → head flit on VC 2 two cycles later.
- Credit return and send on the same VC in the same cycle → credit_r unchanged. Return at N_CREDITS → stays 4.
- rst low during flit 2 of 5 → is_valid_o=0 immediately. After release, credits=4, all VCs free, a new packet starts on VC 0.
